vedic_divider_digit_serial: RTL and testbench
=============================================

# vedic_divider_digit_serial

Parametrised, digit-serial integer divider: the next generation of the cascaded 16-bit divider. It divides a full-width dividend by a full-width divisor, producing DIGIT quotient bits per clock and selectable signed or unsigned mode. It raises an explicit divide-by-zero flag, and latency is fixed and independent of operand values. It sits in the dhvajanka arithmetic datapath as a drop-in multi-cycle divider behind a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT, ≥ 8
- DIGIT, 4, quotient bits resolved per ITER cycle; 1, 2, 4 or 8
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge
- start  input  1  request; accepted only while busy=0
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; captured with start
- dividend  input  WIDTH  captured on accepting edge
- divisor  input  WIDTH  captured on accepting edge
- quotient  output  WIDTH  result, registered; holds until next completion
- remainder  output  WIDTH  result, registered; holds until next completion
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse, results valid in the same cycle
- div_by_zero  output  1  registered with results; high if the captured divisor was 0

## Operation
- Reset: one clock and one reset. Reset is synchronous and active-low (rst_n). While rst_n=0 at a rising edge:
  - state goes to IDLE
  - quotient, remainder, busy, done and div_by_zero go to 0
  - internal operand, partial-remainder and counter registers are cleared
- Reset mid-operation aborts the operation. No done is produced for it.
- Let N = WIDTH/DIGIT.
- States:
  - IDLE: start=1 captures operands and signed_mode, then goes to PREP. start is ignored in every other state.
  - PREP: forms magnitudes. If signed_mode is set and the operand MSB is 1, the operand is negated. It records q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend). It flags the zero divisor, loads the counter with N−1, then goes to ITER.
  - ITER: restoring long division unrolled DIGIT stages per cycle. Each stage does the following:
    - partial remainder (WIDTH+1 bits) = {rem, next dividend MSB}
    - subtract the divisor magnitude; keep the difference if it is non-negative
    - shift in a quotient bit of 1 if the difference was kept, else 0
    - After each cycle the counter decrements; at 0 the block goes to FIXUP. ITER lasts exactly N cycles.
  - FIXUP: registers the outputs, then goes to DONE.
    - Signed: quotient is negated if q_neg; remainder is negated if r_neg.
    - Divide-by-zero overrides the result: quotient = all ones, remainder = captured dividend unchanged, div_by_zero=1. The ITER datapath still runs; its result is discarded.
  - DONE: done=1 for this cycle only, then back to IDLE. busy drops at the same edge.
- Arithmetic rules:
  - Truncation toward zero. Remainder sign follows dividend. |remainder| < |divisor|.
  - Invariant: dividend = quotient·divisor + remainder, modulo 2^WIDTH.
  - Signed overflow (MIN / −1): quotient = MIN (wraps), remainder = 0, div_by_zero=0.
  - Unsigned: all inputs are magnitudes; no negation is applied.
- Inputs may change freely after the accepting edge; the block uses only captured copies.
- A start held high across DONE is accepted again on the first IDLE cycle (back-to-back operations).

## Timing
- Edge E0: start sampled high in IDLE.
- Cycle after E0: PREP, busy=1.
- Next N cycles: ITER.
- Then one FIXUP cycle.
- DONE cycle: done=1, with quotient, remainder and div_by_zero valid. done rises at edge E0+N+2 and is high for the cycle following it.
  - Default parameters (N=8): done is high in the 11th cycle after E0.
- busy is 1 for N+3 cycles. Total accepted-to-accepted throughput is N+4 cycles.
- Latency is identical for zero divisors, signed and unsigned mode, and all operand values.
- Results change only at the FIXUP→DONE edge; outside that edge they are stable.
- Critical path: DIGIT cascaded (WIDTH+1)-bit subtract/mux stages. DIGIT=8 is permitted only if timing closes.

## Test plan
- Unsigned, WIDTH=32, DIGIT=4: 1000/7 -> quotient 142, remainder 6, done pulse exactly 11 cycles after start, busy high 11 cycles; 0xFFFFFFFF/1 -> 0xFFFFFFFF, remainder 0.
- Signed: −7/2 -> −3 r −1; 7/−2 -> −3 r 1; −7/−2 -> 3 r −1; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero 0.
- Divide by zero: 1234/0 unsigned -> quotient 0xFFFFFFFF, remainder 1234, div_by_zero 1, same latency; next valid op clears div_by_zero.
- Handshake: start pulsed mid-ITER is ignored (one done only); start held high continuously -> done every 12 cycles, results match each captured pair; operands changed after acceptance do not affect the result.
- Reset: rst_n low for one edge during ITER -> all outputs 0 on next cycle, no done; a subsequent 100/9 -> 11 r 1 normally.
- Parameter sweep: WIDTH ∈ {8,16,32}, DIGIT ∈ {1,2,4,8}, 10k random signed/unsigned pairs vs reference model; latency = WIDTH/DIGIT+3 each.

Source files
------------

// File: rtl/vedic_divider_digit_serial.sv
// Digit-serial restoring divider: DIGIT quotient bits per cycle, signed/unsigned,
// fixed latency of WIDTH/DIGIT+3 busy cycles with an explicit divide-by-zero flag.
module vedic_divider_digit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;

  logic             r_sm;
  logic [WIDTH-1:0] r_raw_a;
  logic [WIDTH-1:0] r_raw_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_div_by_zero;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_work;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH:0]   w_pr;
  logic [WIDTH:0]   w_diff;

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

  assign w_a_neg = r_sm & r_raw_a[WIDTH-1];
  assign w_b_neg = r_sm & r_raw_b[WIDTH-1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // DIGIT unrolled restoring stages; quotient bits shift into the dividend register
  always_comb begin
    w_rem  = r_rem;
    w_work = r_work;
    w_pr   = '0;
    w_diff = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      w_pr   = {w_rem, w_work[WIDTH-1]};
      w_diff = w_pr - {1'b0, r_dvs};
      w_work = {w_work[WIDTH-2:0], ~w_diff[WIDTH]};
      if (!w_diff[WIDTH]) w_rem = w_diff[WIDTH-1:0];
      else                w_rem = w_pr[WIDTH-1:0];
    end
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sm          <= 1'b0;
      r_raw_a       <= '0;
      r_raw_b       <= '0;
      r_work        <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dz          <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_raw_a <= dividend;
            r_raw_b <= divisor;
            r_sm    <= signed_mode;
          end
        end
        S_PREP: begin
          r_work  <= w_a_neg ? -r_raw_a : r_raw_a;
          r_dvs   <= w_b_neg ? -r_raw_b : r_raw_b;
          r_q_neg <= w_a_neg ^ w_b_neg;
          r_r_neg <= w_a_neg;
          r_dz    <= (r_raw_b == '0);
          r_rem   <= '0;
          r_cnt   <= CNT_LOAD;
        end
        S_ITER: begin
          r_work <= w_work;
          r_rem  <= w_rem;
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIXUP: begin
          // A zero divisor discards the iteration result entirely
          if (r_dz) begin
            r_quotient  <= '1;
            r_remainder <= r_raw_a;
          end else begin
            r_quotient  <= r_q_neg ? -r_work : r_work;
            r_remainder <= r_r_neg ? -r_rem  : r_rem;
          end
          r_div_by_zero <= r_dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_divider_digit_serial.sv
// Randomized self-checking bench for vedic_divider_digit_serial (WIDTH=32, DIGIT=4)
// against a plain-arithmetic division model.
module tb_vedic_divider_digit_serial;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  vedic_divider_digit_serial #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers
  task automatic ref_div(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE
  task automatic run_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit mid_start, input bit held);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int cyc;
    int nbusy;
    int ndone;
    ref_div(sm, a, b, eq, er, ez);
    start       = 1'b1;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    @(negedge clk);
    cyc   = 1;
    nbusy = 0;
    if (!held) start = 1'b0;
    dividend    = $urandom;
    divisor     = $urandom;
    signed_mode = 1'($urandom);
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      if (mid_start) start = (cyc == 5);
      @(negedge clk);
      cyc++;
    end
    if (busy) nbusy++;
    check("latency", 32'(cyc), 32'(LAT));
    check("busy_cycles", 32'(nbusy), 32'(LAT));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("q_hold", quotient, eq);
    if (mid_start) begin
      ndone = 0;
      repeat (14) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check("extra_done", 32'(ndone), 32'd0);
    end
  endtask

  task automatic reset_mid_op();
    int ndone;
    start       = 1'b1;
    signed_mode = 1'b0;
    dividend    = 32'd500;
    divisor     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(negedge clk);
    check("reset_q", quotient, '0);
    check("reset_r", remainder, '0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd1000, 32'd7, 1'b0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, 1'b0, 1'b0);
    run_op(1'b1, 32'd7, -32'sd2, 1'b0, 1'b0);
    run_op(1'b1, -32'sd7, -32'sd2, 1'b0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'd1234, 32'd0, 1'b0, 1'b0);
    run_op(1'b0, 32'd100, 32'd9, 1'b0, 1'b0);
    run_op(1'b1, -32'sd1234, 32'd0, 1'b0, 1'b0);
    run_op(1'b0, 32'd77777, 32'd13, 1'b1, 1'b0);

    // start held high: each operation accepted on the first IDLE cycle
    run_op(1'b0, 32'd5000, 32'd17, 1'b0, 1'b1);
    run_op(1'b1, -32'sd99, 32'd10, 1'b0, 1'b1);
    run_op(1'b0, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);

    reset_mid_op();
    run_op(1'b0, 32'd100, 32'd9, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rs, ra, rb, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
